pac_multi: RTL and testbench

PAC_MULTI -- requirements
Module: pac_multi

---
 rtl/pac_multi.sv | 184 ++++++++++++++++++
 tb/tb_pac_multi.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pac_multi.sv
// pac_multi -- multi-channel phase accumulator sharing a single adder.
//
// A prescaler raises a one-cycle `tick` every DIV clocks. On a tick the
// increments on f_in are snapshotted, then the channels are swept one per
// cycle through a shared adder: channel k's new phase shows on `angle` two
// cycles after the tick plus k. Phases wrap modulo 2^PW and `wrap[k]` pulses
// together with the update that carried out of the top bit.
//
// Optional feature (macro PAC_SYNC_EN): adds input `sync`, snapshotted at the
// tick along with the increments; a set bit makes that channel load zero in
// the sweep instead of accumulating, with no wrap pulse.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   f_in   in   NCH*FW packed increments, channel k at [k*FW +: FW]
//   sync   in   NCH per-channel phase-zero requests (PAC_SYNC_EN only)
//   angle  out  NCH*PW packed registered phases, channel k at [k*PW +: PW]
//   wrap   out  NCH per-channel overflow pulses
//   tick   out  sample-rate strobe
//   busy   out  high while the channel sweep runs
//   done   out  pulse with the last channel update of a sweep
module pac_multi #(
    parameter int NCH = 4,
    parameter int PW  = 16,
    parameter int FW  = 16,
    parameter int DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*FW-1:0] f_in,
`ifdef PAC_SYNC_EN
    input  logic [NCH-1:0]    sync,
`endif
    output logic [NCH*PW-1:0] angle,
    output logic [NCH-1:0]    wrap,
    output logic              tick,
    output logic              busy,
    output logic              done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   inc_q [NCH];
    logic [FW-1:0]   inc_d [NCH];
    logic [PW-1:0]   ang_q [NCH];
    logic [PW-1:0]   ang_d [NCH];
    logic [NCH-1:0]  wrap_q, wrap_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef PAC_SYNC_EN
    logic [NCH-1:0]  sync_q, sync_d;
`endif

    // Shared adder: one extra bit on top captures the carry out of bit PW-1.
    logic [PW:0]     sum_s;
    assign sum_s = {1'b0, ang_q[idx_q]} + {1'b0, PW'(inc_q[idx_q])};

    // Prescaler: counts 0..DIV-1 and strobes tick when it rolls over.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Sweep FSM next-state and datapath: snapshot on tick, then one channel per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        inc_d   = inc_q;
        ang_d   = ang_q;
        wrap_d  = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef PAC_SYNC_EN
        sync_d  = sync_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick_q) begin
                    state_d = RUN;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    for (int k = 0; k < NCH; k++) begin
                        inc_d[k] = f_in[k*FW +: FW];
                    end
`ifdef PAC_SYNC_EN
                    sync_d  = sync;
`endif
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
`ifdef PAC_SYNC_EN
                if (sync_q[idx_q]) begin
                    ang_d[idx_q] = '0;
                end else begin
                    ang_d[idx_q]  = sum_s[PW-1:0];
                    wrap_d[idx_q] = sum_s[PW];
                end
`else
                ang_d[idx_q]  = sum_s[PW-1:0];
                wrap_d[idx_q] = sum_s[PW];
`endif
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            idx_q   <= '0;
            wrap_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                inc_q[k] <= '0;
                ang_q[k] <= '0;
            end
`ifdef PAC_SYNC_EN
            sync_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int k = 0; k < NCH; k++) begin
                inc_q[k] <= inc_d[k];
                ang_q[k] <= ang_d[k];
            end
`ifdef PAC_SYNC_EN
            sync_q  <= sync_d;
`endif
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign angle[g*PW +: PW] = ang_q[g];
    end

    assign wrap = wrap_q;
    assign tick = tick_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pac_multi.sv
// Self-checking bench for pac_multi (NCH=4, PW=16, FW=16, DIV=8).
// A timeline model predicts every output from the cycle count since reset;
// a few directed scenarios pin literal values, then random stimulus runs.
module tb_pac_multi;

    localparam int NCH = 4;
    localparam int PW  = 16;
    localparam int FW  = 16;
    localparam int DIV = 8;

    logic              clk;
    logic              rst;
    logic [NCH*FW-1:0] f_in;
    logic [NCH*PW-1:0] angle;
    logic [NCH-1:0]    wrap;
    logic              tick;
    logic              busy;
    logic              done;
`ifdef PAC_SYNC_EN
    logic [NCH-1:0]    sync;
`endif

    int checks;
    int errors;

    pac_multi #(.NCH(NCH), .PW(PW), .FW(FW), .DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .f_in  (f_in),
`ifdef PAC_SYNC_EN
        .sync  (sync),
`endif
        .angle (angle),
        .wrap  (wrap),
        .tick  (tick),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // c = clock edges since the last reset edge; ticks occur at c = DIV, 2*DIV, ...
    // A sweep triggered by a tick in cycle T shows channel k at T+2+k.
    int            c;
    int            t_start;
    int            kk;
    bit            started;
    bit            act;
    longint        s;
    logic [PW-1:0] m_ang  [NCH];
    logic [FW-1:0] m_inc  [NCH];
    bit            m_sync [NCH];
    logic [NCH-1:0] m_wrap;
    bit            m_tick, m_busy, m_done;
    logic          r_s;
    logic [NCH*FW-1:0] f_s;
    logic [NCH-1:0] sy_s;

    initial begin
        started = 1'b0;
        act     = 1'b0;
        m_tick  = 1'b0;
    end

    always @(posedge clk) begin
        r_s  = rst;
        f_s  = f_in;
`ifdef PAC_SYNC_EN
        sy_s = sync;
`else
        sy_s = '0;
`endif
        if (r_s) begin
            started = 1'b1;
            c       = 0;
            act     = 1'b0;
            m_tick  = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_wrap  = '0;
            for (int k = 0; k < NCH; k++) begin
                m_ang[k]  = '0;
                m_inc[k]  = '0;
                m_sync[k] = 1'b0;
            end
        end else if (started) begin
            c++;
            if (m_tick) begin
                t_start = c - 1;
                act     = 1'b1;
                for (int k = 0; k < NCH; k++) begin
                    m_inc[k]  = f_s[k*FW +: FW];
                    m_sync[k] = sy_s[k];
                end
            end
            m_tick = ((c % DIV) == 0);
            m_wrap = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            if (act) begin
                kk = c - t_start - 2;
                if (kk >= 0 && kk < NCH) begin
                    if (m_sync[kk]) begin
                        m_ang[kk] = '0;
                    end else begin
                        s = longint'(m_ang[kk]) + longint'(m_inc[kk]);
                        m_wrap[kk] = (s >= (64'd1 << PW));
                        m_ang[kk]  = PW'(s % (64'd1 << PW));
                    end
                end
                m_busy = (c >= t_start + 1) && (c <= t_start + NCH);
                m_done = (c == t_start + NCH + 1);
                if (c >= t_start + NCH + 1) act = 1'b0;
            end
        end
        #1;
        if (started) begin
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("angle%0d", k), 64'(angle[k*PW +: PW]), 64'(m_ang[k]));
            end
            check("wrap", 64'(wrap), 64'(m_wrap));
            check("tick", 64'(tick), 64'(m_tick));
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("tick_during_run", 64'(tick & busy), 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 0 (first cycle after the reset edge).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        f_in   = '0;
`ifdef PAC_SYNC_EN
        sync   = '0;
`endif
        go(3);

        // All-zero increments: tick period, done timing, angles stay 0.
        f_in = '0;
        do_reset();
        check("reset_angle", 64'(angle), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        go(8);
        check("z_tick8", 64'(tick), 64'd1);
        go(5);
        check("z_done13", 64'(done), 64'd1);
        go(3);
        check("z_tick16", 64'(tick), 64'd1);

        // Staggered channel updates.
        f_in = {16'd4, 16'd3, 16'd2, 16'd1};
        do_reset();
        go(9);
        check("s_busy9", 64'(busy), 64'd1);
        go(1);
        check("s_ang0_10", 64'(angle[15:0]), 64'd1);
        go(3);
        check("s_ang3_13", 64'(angle[63:48]), 64'd4);
        check("s_done13", 64'(done), 64'd1);

        // Long run with wrap on channel 0.
        f_in = {16'd0, 16'd0, 16'd0, 16'h1000};
        do_reset();
        go(10);
        check("w_ang0_t1", 64'(angle[15:0]), 64'h1000);
        go(112);
        check("w_ang0_t15", 64'(angle[15:0]), 64'hF000);
        go(8);
        check("w_ang0_t16", 64'(angle[15:0]), 64'h0000);
        check("w_wrap0_t16", 64'(wrap), 64'h1);

        // Increment change after the tick is not seen until the next sweep.
        f_in = {16'd0, 16'd0, 16'd0, 16'h0010};
        do_reset();
        go(9);
        f_in = {16'd0, 16'd0, 16'd0, 16'h0100};
        go(1);
        check("c_ang0_10", 64'(angle[15:0]), 64'h0010);
        go(8);
        check("c_ang0_18", 64'(angle[15:0]), 64'h0110);

        // Reset mid-sweep after ch0 and ch1 are updated.
        f_in = {16'd4, 16'd3, 16'd2, 16'd1};
        do_reset();
        go(11);
        check("r_ang1_11", 64'(angle[31:16]), 64'd2);
        rst = 1'b1;
        go(1);
        rst = 1'b0;
        check("r_angle_zero", 64'(angle), 64'd0);
        check("r_done_zero", 64'(done), 64'd0);
        go(7);
        check("r_tick7", 64'(tick), 64'd0);
        go(1);
        check("r_tick8", 64'(tick), 64'd1);

`ifdef PAC_SYNC_EN
        // Sync on channel 2 at the third tick zeroes it without a wrap pulse.
        f_in = {16'd0, 16'h4000, 16'd0, 16'd0};
        do_reset();
        go(12);
        check("y_ang2_12", 64'(angle[47:32]), 64'h4000);
        go(8);
        check("y_ang2_20", 64'(angle[47:32]), 64'h8000);
        go(3);
        sync = 4'b0100;
        go(2);
        sync = 4'b0000;
        go(3);
        check("y_ang2_28", 64'(angle[47:32]), 64'h0000);
        check("y_wrap_28", 64'(wrap), 64'h0);
`endif

        // Randomized stimulus against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                for (int k = 0; k < NCH; k++) begin
                    case ($urandom_range(0, 3))
                        0: f_in[k*FW +: FW] = '0;
                        1: f_in[k*FW +: FW] = FW'($urandom_range(0, 255));
                        2: f_in[k*FW +: FW] = FW'($urandom_range(16'hC000, 16'hFFFF));
                        default: f_in[k*FW +: FW] = FW'($urandom);
                    endcase
                end
            end
`ifdef PAC_SYNC_EN
            if ($urandom_range(0, 7) == 0) begin
                sync = NCH'($urandom) & NCH'($urandom);
            end
`endif
        end
        rst = 1'b0;
        go(2 * DIV);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
